cmd_scheduler: RTL and testbench
================================

// Module: cmd_scheduler
// PURPOSE
//   Top-level sequencer of the coprocessor. Parses UART command lines ("xx\n"),
//   starts the bank loader or the compute engine, and owns the two shared BRAM
//   ports (bank A, bank B), granting each to exactly one requester at a time.
//   Sits between uart_rx and the loader/compute engine; loader and engine never
//   drive BRAM directly.
// PARAMETERS
//   AW          10           BRAM address width (1024 entries per bank)
//   TIMEOUT_CYC 100_000_000  idle-rx cycles in LOAD before abort (1 s @ 100 MHz)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   reset, asynchronous, active-high
//   rx_data    in   8   byte from uart_rx
//   rx_ready   in   1   1-cycle strobe, rx_data valid
//   ld_start   out  1   1-cycle pulse: loader begins filling ld_bank
//   ld_bank    out  1   0=bank A, 1=bank B; held stable through LOAD
//   ld_abort   out  1   1-cycle pulse: loader must drop transfer, return idle
//   ld_done    in   1   loader finished 2**AW bytes
//   ld_en/ld_we in  1   loader BRAM request
//   ld_addr    in   AW  loader address
//   ld_din     in   8   loader write data
//   cp_start   out  1   1-cycle pulse: compute engine begins
//   cp_op      out  2   opcode, held stable through COMPUTE
//   cp_done    in   1   compute finished
//   cp_en      in   1   compute read enable (both banks)
//   cp_addr    in   AW  compute read address (both banks)
//   a_en,a_we  out  1   bank A port;  a_addr out AW;  a_din out 8
//   b_en,b_we  out  1   bank B port;  b_addr out AW;  b_din out 8
//   busy       out  1   state != IDLE
//   cmd_err    out  1   1-cycle pulse: unknown command or command while busy
// BEHAVIOUR
//   Reset: state IDLE; window 24'h0; timeout cnt 0; every output 0.
//   FSM states IDLE, LOAD, COMPUTE, ABORT (all registered).
//   Command window: 24-bit shift reg, shifts rx_data in on rx_ready, IDLE only.
//   Decode when rx_ready && rx_data==8'h0A in IDLE, on {window[15:0],8'h0A}:
//     "wa\n" -> LOAD, ld_bank=0      "wb\n" -> LOAD, ld_bank=1
//     "su\n" -> COMPUTE, cp_op=0     "av\n" -> cp_op=1
//     "mx\n" -> cp_op=2              "mn\n" -> cp_op=3
//     other  -> stay IDLE, cmd_err pulse.
//   Latency: state change, ld_start/cp_start, cmd_err all in cycle after LF strobe.
//   Window cleared to 0 on every transition back to IDLE and on any decode;
//     stale bytes never form a command.
//   LOAD: bytes not decoded (payload may contain "\n"). Timeout cnt clears on
//     rx_ready and on entry; increments otherwise; at TIMEOUT_CYC-1 -> ABORT.
//     ld_done -> IDLE. ld_done and timeout in same cycle: ld_done wins.
//   ABORT: one cycle, ld_abort=1, -> IDLE. Bank contents undefined after abort.
//   COMPUTE: rx bytes ignored except LF -> cmd_err pulse (busy). cp_done -> IDLE.
//     No timeout.
//   ld_done in IDLE/COMPUTE, cp_done in IDLE/LOAD: ignored.
//   Port mux (combinational from registered state/ld_bank):
//     LOAD  : selected bank = ld_en/ld_we/ld_addr/ld_din; other bank all 0.
//     COMPUTE: a_*, b_*: en=cp_en, we=0, addr=cp_addr, din=0.
//     IDLE/ABORT: all bank outputs 0. we never 1 outside LOAD.
//   Reset mid-LOAD/COMPUTE: immediate IDLE, no ld_abort pulse (loader shares rst).
// STRUCTURE
//   coproc_pkg: state enum, op enum (OP_SUM,OP_AVG,OP_MAX,OP_MIN), 16-bit
//     command constants ("wa","wb","su","av","mx","mn"), ASCII_LF.
//   Sub-module cmd_decoder: window reg + decode -> {cmd_valid, cmd_is_load,
//     bank, op, cmd_unknown}. Scheduler keeps FSM, timeout, port mux.
// TESTING
//   "wa\n" -> ld_start 1 cycle after LF, ld_bank=0, busy=1; ld_we=1,ld_addr=5
//     -> a_we=1,a_addr=5, b_* all 0; ld_done -> IDLE next cycle, busy=0.
//   "wb\n", payload with 8'h0A bytes -> no cmd_err, stays LOAD; ld_done -> IDLE.
//   "zz\n" -> cmd_err 1 cycle, busy=0; then "av\n" -> cp_start, cp_op=1.
//   "su\n", send "wa\n" during COMPUTE -> cmd_err, no ld_start; cp_en=1,
//     cp_addr=3 -> a_addr=b_addr=3, a_we=b_we=0.
//   TIMEOUT_CYC=16: "wa\n", no rx -> ABORT at cycle 16, ld_abort 1 cycle, IDLE;
//     ld_done coincident with timeout -> IDLE, no ld_abort.
//   rst asserted mid-LOAD (async, off clock edge) -> outputs 0 immediately;
//     "a\n" after release -> cmd_err (window cleared).

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor command path.
//   state_t : scheduler FSM states
//   op_t    : compute-engine opcodes
//   CMD_*   : two-character ASCII command words (first char in the upper byte)
//   ASCII_LF: command terminator
package coproc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_ABORT
  } state_t;

  typedef enum logic [1:0] {
    OP_SUM,
    OP_AVG,
    OP_MAX,
    OP_MIN
  } op_t;

  localparam logic [7:0]  ASCII_LF = 8'h0A;

  localparam logic [15:0] CMD_WA = 16'h7761; // "wa"
  localparam logic [15:0] CMD_WB = 16'h7762; // "wb"
  localparam logic [15:0] CMD_SU = 16'h7375; // "su"
  localparam logic [15:0] CMD_AV = 16'h6176; // "av"
  localparam logic [15:0] CMD_MX = 16'h6d78; // "mx"
  localparam logic [15:0] CMD_MN = 16'h6d6e; // "mn"

endpackage

// File: rtl/cmd_decoder.sv
// Command window and decoder.
//   clk, rst     : clock, async active-high reset
//   rx_data/ready: UART byte and its 1-cycle strobe
//   idle         : scheduler is in IDLE (window only shifts and decodes here)
//   clear        : scheduler is returning to IDLE; window is wiped
//   cmd_valid    : LF seen in IDLE and the two preceding bytes form a known command
//   cmd_is_load  : decoded command is a bank load (bank selects A/B)
//   op           : decoded compute opcode
//   cmd_unknown  : LF seen in IDLE but the window holds no known command
module cmd_decoder
  import coproc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       idle,
  input  logic       clear,
  output logic       cmd_valid,
  output logic       cmd_is_load,
  output logic       bank,
  output op_t        op,
  output logic       cmd_unknown
);

  logic [23:0] window_q, window_d;
  logic        lf_strobe;
  logic        known;

  // Oldest byte is kept for history only; decode looks at the last two.
  logic unused_oldest;
  assign unused_oldest = ^window_q[23:16];

  always_comb begin
    lf_strobe   = idle && rx_ready && (rx_data == ASCII_LF);
    known       = 1'b1;
    cmd_is_load = 1'b0;
    bank        = 1'b0;
    op          = OP_SUM;
    case (window_q[15:0])
      CMD_WA: cmd_is_load = 1'b1;
      CMD_WB: begin
        cmd_is_load = 1'b1;
        bank        = 1'b1;
      end
      CMD_SU: op = OP_SUM;
      CMD_AV: op = OP_AVG;
      CMD_MX: op = OP_MAX;
      CMD_MN: op = OP_MIN;
      default: known = 1'b0;
    endcase
    cmd_valid   = lf_strobe && known;
    cmd_unknown = lf_strobe && !known;

    // Any decode wipes the window so leftover bytes can never pair with
    // later input to form a command.
    if (clear || lf_strobe) begin
      window_d = '0;
    end else if (idle && rx_ready) begin
      window_d = {window_q[15:0], rx_data};
    end else begin
      window_d = window_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) window_q <= '0;
    else     window_q <= window_d;
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Top-level coprocessor sequencer: parses "xx\n" commands, starts the bank
// loader or compute engine, and owns the bank A / bank B BRAM ports.
//   rx_data/rx_ready          : UART receive byte + strobe
//   ld_start/ld_bank/ld_abort : loader control (registered)
//   ld_done, ld_en/we/addr/din: loader status and BRAM request
//   cp_start/cp_op            : compute control (registered)
//   cp_done, cp_en/cp_addr    : compute status and read request (both banks)
//   a_*, b_*                  : bank A / bank B BRAM ports
//   busy, cmd_err             : status (registered)
module cmd_scheduler
  import coproc_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic          ld_start,
  output logic          ld_bank,
  output logic          ld_abort,
  input  logic          ld_done,
  input  logic          ld_en,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_din,
  output logic          cp_start,
  output logic [1:0]    cp_op,
  input  logic          cp_done,
  input  logic          cp_en,
  input  logic [AW-1:0] cp_addr,
  output logic          a_en,
  output logic          a_we,
  output logic [AW-1:0] a_addr,
  output logic [7:0]    a_din,
  output logic          b_en,
  output logic          b_we,
  output logic [AW-1:0] b_addr,
  output logic [7:0]    b_din,
  output logic          busy,
  output logic          cmd_err
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_start_q, ld_start_d;
  logic             ld_abort_q, ld_abort_d;
  logic             ld_bank_q, ld_bank_d;
  logic             cp_start_q, cp_start_d;
  op_t              cp_op_q, cp_op_d;
  logic             cmd_err_q, cmd_err_d;
  logic             busy_q, busy_d;

  logic dec_valid, dec_is_load, dec_bank, dec_unknown, win_clear;
  op_t  dec_op;

  cmd_decoder u_decoder (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .idle       (state_q == ST_IDLE),
    .clear      (win_clear),
    .cmd_valid  (dec_valid),
    .cmd_is_load(dec_is_load),
    .bank       (dec_bank),
    .op         (dec_op),
    .cmd_unknown(dec_unknown)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_start_d = 1'b0;
    ld_abort_d = 1'b0;
    cp_start_d = 1'b0;
    cmd_err_d  = 1'b0;
    ld_bank_d  = ld_bank_q;
    cp_op_d    = cp_op_q;
    case (state_q)
      ST_IDLE: begin
        if (dec_valid) begin
          if (dec_is_load) begin
            state_d    = ST_LOAD;
            ld_bank_d  = dec_bank;
            ld_start_d = 1'b1;
          end else begin
            state_d    = ST_COMPUTE;
            cp_op_d    = dec_op;
            cp_start_d = 1'b1;
          end
        end else if (dec_unknown) begin
          cmd_err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        // ld_done takes priority over a timeout landing in the same cycle.
        if (ld_done) begin
          state_d = ST_IDLE;
        end else if (rx_ready) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_ABORT;
          ld_abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      ST_COMPUTE: begin
        if (rx_ready && (rx_data == ASCII_LF)) cmd_err_d = 1'b1;
        if (cp_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Counter starts from zero on every LOAD entry.
    if (state_d != ST_LOAD) cnt_d = '0;
    busy_d    = (state_d != ST_IDLE);
    win_clear = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ld_start_q <= 1'b0;
      ld_abort_q <= 1'b0;
      ld_bank_q  <= 1'b0;
      cp_start_q <= 1'b0;
      cp_op_q    <= OP_SUM;
      cmd_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_start_q <= ld_start_d;
      ld_abort_q <= ld_abort_d;
      ld_bank_q  <= ld_bank_d;
      cp_start_q <= cp_start_d;
      cp_op_q    <= cp_op_d;
      cmd_err_q  <= cmd_err_d;
      busy_q     <= busy_d;
    end
  end

  assign ld_start = ld_start_q;
  assign ld_abort = ld_abort_q;
  assign ld_bank  = ld_bank_q;
  assign cp_start = cp_start_q;
  assign cp_op    = cp_op_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = busy_q;

  // Port ownership follows the registered state; write enables only in LOAD.
  always_comb begin
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
    case (state_q)
      ST_LOAD: begin
        if (!ld_bank_q) begin
          a_en = ld_en; a_we = ld_we; a_addr = ld_addr; a_din = ld_din;
        end else begin
          b_en = ld_en; b_we = ld_we; b_addr = ld_addr; b_din = ld_din;
        end
      end
      ST_COMPUTE: begin
        a_en = cp_en; a_addr = cp_addr;
        b_en = cp_en; b_addr = cp_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler (TIMEOUT_CYC shortened to 16).
module tb_cmd_scheduler;

  localparam int unsigned AW = 10;
  localparam int unsigned TO = 16;
  localparam logic [7:0]  LF = 8'h0A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          ld_start, ld_bank, ld_abort;
  logic          ld_done = 1'b0, ld_en = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_din = '0;
  logic          cp_start;
  logic [1:0]    cp_op;
  logic          cp_done = 1'b0, cp_en = 1'b0;
  logic [AW-1:0] cp_addr = '0;
  logic          a_en, a_we, b_en, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [7:0]    a_din, b_din;
  logic          busy, cmd_err;

  cmd_scheduler #(.AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_abort(ld_abort), .ld_done(ld_done),
    .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_din(ld_din),
    .cp_start(cp_start), .cp_op(cp_op), .cp_done(cp_done), .cp_en(cp_en), .cp_addr(cp_addr),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [39:0] bank_bus;
  logic [7:0]  regs;
  assign bank_bus = {a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din};
  assign regs     = {ld_start, ld_abort, cp_start, cmd_err, busy, ld_bank, cp_op};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    rx_data  = '0;
  endtask

  task automatic clear_inputs();
    rx_ready = 0; rx_data = '0; ld_done = 0; ld_en = 0; ld_we = 0;
    ld_addr = '0; ld_din = '0; cp_done = 0; cp_en = 0; cp_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    step();
  endtask

  // ---------------- behavioural reference model ----------------
  string            m_mode;
  logic [7:0]       hist[$];
  int               idle_cnt;
  bit               m_bank;
  bit [1:0]         m_op;
  logic [7:0]       exp_regs;
  int               cmd_map[int];

  function automatic int key2(input logic [7:0] c1, input logic [7:0] c0);
    return int'(c1) * 256 + int'(c0);
  endfunction

  task automatic model_reset();
    m_mode = "idle"; hist.delete(); idle_cnt = 0; m_bank = 0; m_op = 0;
  endtask

  function automatic logic [39:0] model_ports();
    logic [19:0] ldb, cpb;
    ldb = {ld_en, ld_we, ld_addr, ld_din};
    cpb = {cp_en, 1'b0, cp_addr, 8'h00};
    if (m_mode == "load")    return m_bank ? {20'd0, ldb} : {ldb, 20'd0};
    if (m_mode == "compute") return {cpb, cpb};
    return '0;
  endfunction

  task automatic model_step();
    bit st = 0, ab = 0, cs = 0, er = 0;
    int key, n;
    if (m_mode == "idle") begin
      if (rx_ready) begin
        if (rx_data == LF) begin
          n   = hist.size();
          key = key2(n >= 2 ? hist[n-2] : 8'h00, n >= 1 ? hist[n-1] : 8'h00);
          hist.delete();
          if (cmd_map.exists(key)) begin
            if (cmd_map[key] >= 200) begin
              m_mode = "compute"; m_op = 2'(cmd_map[key] - 200); cs = 1;
            end else begin
              m_mode = "load"; m_bank = 1'(cmd_map[key] - 100); st = 1; idle_cnt = 0;
            end
          end else begin
            er = 1;
          end
        end else begin
          hist.push_back(rx_data);
          if (hist.size() > 2) hist.delete(0);
        end
      end
    end else if (m_mode == "load") begin
      if (ld_done) m_mode = "idle";
      else if (rx_ready) idle_cnt = 0;
      else begin
        idle_cnt++;
        if (idle_cnt == TO) begin m_mode = "abort"; ab = 1; end
      end
    end else if (m_mode == "abort") begin
      m_mode = "idle";
    end else begin
      if (rx_ready && rx_data == LF) er = 1;
      if (cp_done) m_mode = "idle";
    end
    exp_regs = {st, ab, cs, er, (m_mode != "idle"), m_bank, m_op};
  endtask

  // ---------------- command table ----------------
  typedef struct {
    logic [7:0] c1, c0;
    bit         ld, bnk, cp;
    bit [1:0]   op;
    bit         err;
  } vec_t;
  vec_t vecs[10];

  logic [7:0] stream[$];
  string      cmds  = "wawbsuavmxmn";
  string      alpha = "wabsuvmxnz\n";

  task automatic refill();
    int r, k;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      k = $urandom_range(0, 5);
      stream.push_back(cmds[2*k]); stream.push_back(cmds[2*k+1]); stream.push_back(LF);
    end else if (r < 8) begin
      repeat ($urandom_range(1, 3)) stream.push_back(alpha[$urandom_range(0, 9)]);
      stream.push_back(LF);
    end else begin
      repeat ($urandom_range(1, 4)) stream.push_back(alpha[$urandom_range(0, 10)]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rate;
    cmd_map[key2("w", "a")] = 100; cmd_map[key2("w", "b")] = 101;
    cmd_map[key2("s", "u")] = 200; cmd_map[key2("a", "v")] = 201;
    cmd_map[key2("m", "x")] = 202; cmd_map[key2("m", "n")] = 203;

    vecs[0] = '{"w", "a", 1, 0, 0, 0, 0};
    vecs[1] = '{"w", "b", 1, 1, 0, 0, 0};
    vecs[2] = '{"s", "u", 0, 0, 1, 0, 0};
    vecs[3] = '{"a", "v", 0, 0, 1, 1, 0};
    vecs[4] = '{"m", "x", 0, 0, 1, 2, 0};
    vecs[5] = '{"m", "n", 0, 0, 1, 3, 0};
    vecs[6] = '{"z", "z", 0, 0, 0, 0, 1};
    vecs[7] = '{"a", "w", 0, 0, 0, 0, 1};
    vecs[8] = '{"W", "a", 0, 0, 0, 0, 1};
    vecs[9] = '{"w", "s", 0, 0, 0, 0, 1};

    do_reset();
    check("reset_regs", regs, 8'h00);
    check("reset_ports", bank_bus, 40'h0);

    // Table of commands
    foreach (vecs[i]) begin
      send(vecs[i].c1); send(vecs[i].c0); send(LF);
      check("tbl_flags", {ld_start, cp_start, cmd_err, busy},
            {vecs[i].ld, vecs[i].cp, vecs[i].err, vecs[i].ld | vecs[i].cp});
      if (vecs[i].ld) check("tbl_bank", ld_bank, vecs[i].bnk);
      if (vecs[i].cp) check("tbl_op", cp_op, vecs[i].op);
      ld_done = vecs[i].ld; cp_done = vecs[i].cp;
      step();
      ld_done = 0; cp_done = 0;
      check("tbl_back_idle", {busy, ld_start, cp_start, cmd_err}, 4'b0000);
    end

    // "wa\n": loader owns bank A only
    send("w"); send("a"); send(LF);
    check("wa_start", {ld_start, busy, ld_bank, cp_start, cmd_err}, 5'b11000);
    ld_en = 1; ld_we = 1; ld_addr = 10'd5; ld_din = 8'h3C; #1;
    check("wa_ports", bank_bus, {1'b1, 1'b1, 10'd5, 8'h3C, 20'd0});
    step();
    check("wa_start_pulse", {ld_start, busy}, 2'b01);
    ld_done = 1; step(); ld_done = 0;
    check("wa_done_idle", busy, 1'b0);
    check("wa_idle_ports", bank_bus, 40'h0);
    clear_inputs();

    // "wb\n" with LF bytes in the payload
    send("w"); send("b"); send(LF);
    check("wb_start", {ld_start, busy, ld_bank}, 3'b111);
    ld_en = 1; ld_we = 1; ld_addr = 10'h3FF; ld_din = 8'hFF; #1;
    check("wb_ports", bank_bus, {20'd0, 1'b1, 1'b1, 10'h3FF, 8'hFF});
    send(LF); send("s"); send("u"); send(LF);
    check("wb_payload", {cmd_err, busy, cp_start, ld_start}, 4'b0100);
    ld_done = 1; step(); ld_done = 0;
    check("wb_done_idle", busy, 1'b0);
    clear_inputs();

    // Unknown command, then a valid one
    send("z"); send("z"); send(LF);
    check("zz_err", {cmd_err, busy}, 2'b10);
    step();
    check("zz_err_pulse", cmd_err, 1'b0);
    send("a"); send("v"); send(LF);
    check("av_start", {cp_start, cp_op, busy}, 4'b1011);
    cp_done = 1; step(); cp_done = 0;

    // Command during COMPUTE is rejected; compute reads both banks
    send("s"); send("u"); send(LF);
    check("su_start", {cp_start, cp_op, busy}, 4'b1001);
    send("w"); send("a"); send(LF);
    check("busy_cmd_err", {cmd_err, ld_start, busy}, 3'b101);
    ld_en = 1; ld_we = 1; cp_en = 1; cp_addr = 10'd3; #1;
    check("cp_ports", bank_bus, {1'b1, 1'b0, 10'd3, 8'h00, 1'b1, 1'b0, 10'd3, 8'h00});
    cp_done = 1; step();
    check("cp_done_idle", busy, 1'b0);
    clear_inputs();

    // Timeout after 16 idle cycles
    send("w"); send("a"); send(LF);
    for (int i = 1; i < int'(TO); i++) begin
      step();
      check("to_wait", {ld_abort, busy}, 2'b01);
    end
    step();
    check("to_abort", {ld_abort, busy}, 2'b11);
    step();
    check("to_idle", {ld_abort, busy}, 2'b00);

    // rx byte restarts the timeout
    send("w"); send("a"); send(LF);
    repeat (10) step();
    send(8'h55);
    for (int i = 1; i < int'(TO); i++) begin
      step();
      check("to_rearm_wait", {ld_abort, busy}, 2'b01);
    end
    step();
    check("to_rearm_abort", {ld_abort, busy}, 2'b11);
    step();

    // ld_done coincident with timeout wins
    send("w"); send("a"); send(LF);
    repeat (TO - 1) step();
    ld_done = 1; step(); ld_done = 0;
    check("to_vs_done", {ld_abort, busy}, 2'b00);
    step();
    check("to_vs_done_after", {ld_abort, busy}, 2'b00);

    // Asynchronous reset mid-LOAD
    send("w"); send("a"); send(LF);
    ld_en = 1; ld_we = 1; ld_addr = 10'd7; #1;
    check("rst_pre_we", a_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_regs", regs, 8'h00);
    check("rst_async_ports", bank_bus, 40'h0);
    clear_inputs();
    @(negedge clk); rst = 1'b0;
    step();
    send("a"); send(LF);
    check("rst_stale_a", {cmd_err, busy, ld_start}, 3'b100);
    step();

    // Randomised run against the reference model
    do_reset();
    model_reset();
    rate = 3;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) rate = ($urandom_range(0, 1) == 0) ? 3 : 24;
      if (stream.size() == 0) refill();
      if ($urandom_range(0, rate - 1) == 0) begin
        rx_ready = 1; rx_data = stream.pop_front();
      end else begin
        rx_ready = 0; rx_data = 8'($urandom);
      end
      ld_done = ($urandom_range(0, 39) == 0);
      cp_done = ($urandom_range(0, 14) == 0);
      ld_en   = 1'($urandom); ld_we = 1'($urandom);
      ld_addr = AW'($urandom); ld_din = 8'($urandom);
      cp_en   = 1'($urandom); cp_addr = AW'($urandom);
      #1;
      check("rand_ports", bank_bus, model_ports());
      model_step();
      step();
      check("rand_regs", regs, exp_regs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
